// File: rtl/ps2_key_receiver.sv
// ps2_key_receiver: PS/2 keyboard deframer with set-2 E0/F0 prefix decoding into key events
// Ports: CLK_25MHZ/RESET (sync, active-high); PS2_CLK/PS2_DATA raw async pins;
//   RX_DATA/RX_VALID/RX_ERROR frame byte, good-frame pulse and error pulse;
//   KEY_CODE/KEY_EXTENDED/KEY_RELEASED/KEY_VALID decoded key event and its pulse.
module ps2_key_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLK_25MHZ,
  input  logic       RESET,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       RX_ERROR,
  output logic [7:0] KEY_CODE,
  output logic       KEY_EXTENDED,
  output logic       KEY_RELEASED,
  output logic       KEY_VALID
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic filt_q, filt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic par_ok_q, par_ok_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0] rx_data_q, rx_data_d, key_code_q, key_code_d;
  logic rx_valid_q, rx_valid_d, rx_error_q, rx_error_d;
  logic key_ext_q, key_ext_d, key_rel_q, key_rel_d, key_valid_q, key_valid_d;
  logic ext_q, ext_d, rel_q, rel_d;
  logic clk_s, data_s, flip, strobe;
  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  // flip: the synced clock has disagreed with the filtered one for FILTER_LEN samples in a row
  assign flip   = (clk_s != filt_q) && (filt_cnt_q == FW'(FILTER_LEN - 1));
  assign strobe = flip && !clk_s;
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], PS2_CLK};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], PS2_DATA};
    filt_cnt_d  = (clk_s == filt_q || flip) ? '0 : filt_cnt_q + 1'b1;
    filt_d      = flip ? clk_s : filt_q;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_ok_d    = par_ok_q;
    tmo_d       = (state_q != IDLE) ? tmo_q + 1'b1 : '0;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_error_d  = 1'b0;
    if (strobe) begin
      tmo_d = '0;
      case (state_q)
        IDLE: begin
          state_d   = data_s ? IDLE : DATA;
          bit_cnt_d = '0;
        end
        DATA: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          state_d   = (bit_cnt_q == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_ok_d = ^{shift_q, data_s};
          state_d  = STOP;
        end
        default: begin
          state_d    = IDLE;
          rx_valid_d = data_s && par_ok_q;
          rx_error_d = !(data_s && par_ok_q);
          rx_data_d  = (data_s && par_ok_q) ? shift_q : rx_data_q;
        end
      endcase
    end else if (state_q != IDLE && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d    = IDLE;
      tmo_d      = '0;
      rx_error_d = 1'b1;
    end
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_rel_d   = key_rel_q;
    key_valid_d = 1'b0;
    ext_d       = ext_q;
    rel_d       = rel_q;
    if (rx_error_q) begin
      ext_d = 1'b0;
      rel_d = 1'b0;
    end else if (rx_valid_q) begin
      if (rx_data_q == 8'hE0) ext_d = 1'b1;
      else if (rx_data_q == 8'hF0) rel_d = 1'b1;
      else begin
        key_code_d  = rx_data_q;
        key_ext_d   = ext_q;
        key_rel_d   = rel_q;
        key_valid_d = 1'b1;
        ext_d       = 1'b0;
        rel_d       = 1'b0;
      end
    end
  end
  always_ff @(posedge CLK_25MHZ) begin
    if (RESET) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      filt_cnt_q  <= '0;
      filt_q      <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_ok_q    <= 1'b0;
      tmo_q       <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_error_q  <= 1'b0;
      key_code_q  <= '0;
      key_ext_q   <= 1'b0;
      key_rel_q   <= 1'b0;
      key_valid_q <= 1'b0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      filt_cnt_q  <= filt_cnt_d;
      filt_q      <= filt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_ok_q    <= par_ok_d;
      tmo_q       <= tmo_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_error_q  <= rx_error_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_rel_q   <= key_rel_d;
      key_valid_q <= key_valid_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
    end
  end
  assign RX_DATA      = rx_data_q;
  assign RX_VALID     = rx_valid_q;
  assign RX_ERROR     = rx_error_q;
  assign KEY_CODE     = key_code_q;
  assign KEY_EXTENDED = key_ext_q;
  assign KEY_RELEASED = key_rel_q;
  assign KEY_VALID    = key_valid_q;
endmodule
